// File: rtl/rd_sync_nbit_filt.sv
// rd_sync_nbit_filt: WIDTH-bit quasi-static bus synchroniser with a stability filter.
// A word is forwarded only after it has been bit-for-bit stable for STABLE_CYCLES
// consecutive comparisons. The block also provides a change strobe, a valid flag and
// a sticky alarm for inputs that never settle.
module rd_sync_nbit_filt #(
    parameter int unsigned      WIDTH          = 32,
    parameter int unsigned      SYNC_STAGES    = 2,
    parameter int unsigned      STABLE_CYCLES  = 1,
    parameter int unsigned      UNSTABLE_LIMIT = 1024,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] ASYNC_IN,
    input  logic             UNSTABLE_CLR,
    output logic [WIDTH-1:0] SYNC_OUT,
    output logic             SYNC_VALID,
    output logic             CHANGED,
    output logic             UNSTABLE
);

    localparam int unsigned      RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned      UNS_W   = $clog2(UNSTABLE_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [UNS_W-1:0] UNS_MAX = UNS_W'(UNSTABLE_LIMIT);

    // Stage 0 is the asynchronous capture point; every stage is a synchroniser flop.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    logic [WIDTH-1:0] s_val;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] out_q;
    logic [RUN_W-1:0] run_q;
    logic [UNS_W-1:0] uns_q;
    logic             valid_q;
    logic             changed_q;
    logic             unstable_q;

    logic             match_c;
    logic             accept_c;
    logic             settled_c;
    logic             uns_clr_c;
    logic             uns_set_c;
    logic [RUN_W-1:0] run_next_c;
    logic [UNS_W-1:0] uns_next_c;

    assign s_val = sync_q[SYNC_STAGES-1];

    // Per-bit shift chain; bit skew is tolerated because the filter waits for a stable word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ASYNC_IN};
        end
    end

    // Stability comparison, run length, acceptance and settle-timeout bookkeeping.
    always_comb begin
        match_c    = 1'b0;
        accept_c   = 1'b0;
        settled_c  = 1'b0;
        uns_clr_c  = 1'b0;
        uns_set_c  = 1'b0;
        run_next_c = '0;
        uns_next_c = '0;

        match_c  = (s_val == hold_q);
        accept_c = match_c && ((32'(run_q) + 32'd1) >= STABLE_CYCLES);

        if (match_c) begin
            run_next_c = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
        end

        // Nothing pending when both the synchronised word and its delayed copy equal the output.
        settled_c = (s_val == out_q) && (hold_q == out_q);
        uns_clr_c = accept_c || settled_c;

        if (!uns_clr_c) begin
            uns_next_c = (uns_q >= UNS_MAX) ? UNS_MAX : uns_q + UNS_W'(1);
        end

        uns_set_c = !uns_clr_c && (uns_next_c == UNS_MAX);
    end

    // Hold register, filter state and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q     <= RESET_VALUE;
            out_q      <= RESET_VALUE;
            run_q      <= '0;
            uns_q      <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            unstable_q <= 1'b0;
        end else begin
            hold_q <= s_val;
            run_q  <= run_next_c;
            uns_q  <= uns_next_c;

            if (accept_c) begin
                out_q     <= hold_q;
                valid_q   <= 1'b1;
                changed_q <= (hold_q != out_q);
            end else begin
                changed_q <= 1'b0;
            end

            // A fresh timeout wins over a simultaneous clear request.
            if (uns_set_c) begin
                unstable_q <= 1'b1;
            end else if (UNSTABLE_CLR) begin
                unstable_q <= 1'b0;
            end
        end
    end

    assign SYNC_OUT   = out_q;
    assign SYNC_VALID = valid_q;
    assign CHANGED    = changed_q;
    assign UNSTABLE   = unstable_q;

endmodule

// File: tb/tb_rd_sync_nbit_filt.sv
// Bench for rd_sync_nbit_filt: directed checks on two configurations plus a randomised
// 1-bit instance compared cycle-by-cycle against a window-based reference model.
module tb_rd_sync_nbit_filt;

    localparam int unsigned C_SS  = 2;
    localparam int unsigned C_SC  = 3;
    localparam int unsigned C_LIM = 8;
    localparam logic        C_RV  = 1'b1;

    logic        CLK;
    logic        rst;

    logic [31:0] a_in, a_out;
    logic        a_clr, a_valid, a_chg, a_unst;
    logic [15:0] b_in, b_out;
    logic        b_clr, b_valid, b_chg, b_unst;
    logic        c_in, c_out;
    logic        c_clr, c_valid, c_chg, c_unst;

    int errors = 0;
    int checks = 0;

    // Default configuration.
    rd_sync_nbit_filt u_a (
        .CLK(CLK), .RST(rst), .ASYNC_IN(a_in), .UNSTABLE_CLR(a_clr),
        .SYNC_OUT(a_out), .SYNC_VALID(a_valid), .CHANGED(a_chg), .UNSTABLE(a_unst)
    );

    // Deep filter, short alarm, non-zero reset value.
    rd_sync_nbit_filt #(
        .WIDTH(16), .SYNC_STAGES(3), .STABLE_CYCLES(4), .UNSTABLE_LIMIT(16),
        .RESET_VALUE(16'h1234)
    ) u_b (
        .CLK(CLK), .RST(rst), .ASYNC_IN(b_in), .UNSTABLE_CLR(b_clr),
        .SYNC_OUT(b_out), .SYNC_VALID(b_valid), .CHANGED(b_chg), .UNSTABLE(b_unst)
    );

    // Single-bit instance for the randomised comparison.
    rd_sync_nbit_filt #(
        .WIDTH(1), .SYNC_STAGES(C_SS), .STABLE_CYCLES(C_SC), .UNSTABLE_LIMIT(C_LIM),
        .RESET_VALUE(C_RV)
    ) u_c (
        .CLK(CLK), .RST(rst), .ASYNC_IN(c_in), .UNSTABLE_CLR(c_clr),
        .SYNC_OUT(c_out), .SYNC_VALID(c_valid), .CHANGED(c_chg), .UNSTABLE(c_unst)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model for u_c: a word is accepted when the last STABLE_CYCLES+1 observations
    // of the synchronised value since reset are identical.
    logic m_pipe[$];
    logic m_hist[$];
    logic m_out   = C_RV;
    logic m_valid = 1'b0;
    logic m_chg   = 1'b0;
    logic m_unst  = 1'b0;
    int   m_u     = 0;

    always @(posedge CLK) begin
        logic s;
        logic hp;
        bit   acc;
        bit   clear;
        int   un;
        if (rst) begin
            m_pipe  = {};
            for (int j = 0; j < int'(C_SS); j++) m_pipe.push_back(C_RV);
            m_hist  = {};
            m_hist.push_back(C_RV);
            m_out   = C_RV;
            m_valid = 1'b0;
            m_chg   = 1'b0;
            m_unst  = 1'b0;
            m_u     = 0;
        end else begin
            s  = m_pipe[0];
            hp = m_hist[$];
            m_hist.push_back(s);
            if (m_hist.size() > int'(C_SC) + 1) void'(m_hist.pop_front());
            acc = (m_hist.size() == int'(C_SC) + 1);
            foreach (m_hist[j]) if (m_hist[j] != s) acc = 1'b0;
            clear = acc || (s == m_out && hp == m_out);
            un = clear ? 0 : ((m_u + 1 > int'(C_LIM)) ? int'(C_LIM) : m_u + 1);
            if (!clear && un == int'(C_LIM)) m_unst = 1'b1;
            else if (c_clr) m_unst = 1'b0;
            if (acc) begin
                m_chg   = (s != m_out);
                m_out   = s;
                m_valid = 1'b1;
            end else begin
                m_chg = 1'b0;
            end
            m_u = un;
            m_pipe.push_back(c_in);
            void'(m_pipe.pop_front());
        end
    end

    initial begin
        rst   = 1'b1;
        a_in  = 32'h0;
        a_clr = 1'b0;
        b_in  = 16'h1234;
        b_clr = 1'b0;
        c_in  = 1'b1;
        c_clr = 1'b0;

        // Reset state
        step();
        chk("a_rst_out",   a_out, 32'h0);
        chk("a_rst_valid", 32'(a_valid), 32'h0);
        chk("a_rst_chg",   32'(a_chg), 32'h0);
        chk("a_rst_unst",  32'(a_unst), 32'h0);
        chk("b_rst_out",   32'(b_out), 32'h1234);
        chk("b_rst_valid", 32'(b_valid), 32'h0);
        rst = 1'b0;

        // Zero held: valid within three edges, no change pulse
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_zero_chg", 32'(a_chg), 32'h0);
        end
        chk("a_zero_valid", 32'(a_valid), 32'h1);
        chk("a_zero_out",   a_out, 32'h0);
        chk("a_zero_unst",  32'(a_unst), 32'h0);

        // Step to DEADBEEF: visible three edges after stage-1 capture
        a_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_step_hold", a_out, 32'h0);
            chk("a_step_chg0", 32'(a_chg), 32'h0);
        end
        step();
        chk("a_step_out", a_out, 32'hDEAD_BEEF);
        chk("a_step_chg", 32'(a_chg), 32'h1);
        step();
        chk("a_step_out2", a_out, 32'hDEAD_BEEF);
        chk("a_step_chg2", 32'(a_chg), 32'h0);

        // Deep filter: settle on 0x5
        b_in = 16'h0005;
        repeat (12) step();
        chk("b_five_out",   32'(b_out), 32'h5);
        chk("b_five_valid", 32'(b_valid), 32'h1);

        // Three-cycle glitch to 0xA is rejected
        for (int i = 0; i < 15; i++) begin
            b_in = (i < 3) ? 16'h000A : 16'h0005;
            step();
            chk("b_glitch_out", 32'(b_out), 32'h5);
            chk("b_glitch_chg", 32'(b_chg), 32'h0);
        end

        // 0xA held: accepted exactly seven edges after capture
        b_in = 16'h000A;
        repeat (7) step();
        chk("b_a_early", 32'(b_out), 32'h5);
        step();
        chk("b_a_out", 32'(b_out), 32'hA);
        chk("b_a_chg", 32'(b_chg), 32'h1);
        step();
        chk("b_a_chg2", 32'(b_chg), 32'h0);
        chk("b_a_unst", 32'(b_unst), 32'h0);

        // Toggle bit 0 every cycle: alarm after sixteen unaccepted cycles
        for (int i = 0; i < 30; i++) begin
            b_in = 16'h000A ^ 16'(i % 2 == 0);
            step();
            if (i == 17) chk("b_tog_unst_pre", 32'(b_unst), 32'h0);
            if (i == 18) chk("b_tog_unst_set", 32'(b_unst), 32'h1);
        end
        chk("b_tog_out", 32'(b_out), 32'hA);

        // Settle: value accepted while the alarm stays sticky
        b_in = 16'h00FF;
        repeat (12) step();
        chk("b_ff_out",  32'(b_out), 32'hFF);
        chk("b_ff_unst", 32'(b_unst), 32'h1);

        // Clear pulse drops the alarm
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        chk("b_clr_unst", 32'(b_unst), 32'h0);

        // Set and clear in the same cycle: set wins
        for (int i = 0; i < 25; i++) begin
            b_in  = 16'h00FF ^ 16'(i % 2 == 0);
            b_clr = (i == 24);
            step();
        end
        b_clr = 1'b0;
        chk("b_setclr_unst", 32'(b_unst), 32'h1);

        // Reset while a change to 0xFFFF is pending
        b_in = 16'h1234;
        repeat (12) step();
        chk("b_pre_out", 32'(b_out), 32'h1234);
        b_in = 16'hFFFF;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("b_mid_out",   32'(b_out), 32'h1234);
        chk("b_mid_valid", 32'(b_valid), 32'h0);
        chk("b_mid_chg",   32'(b_chg), 32'h0);
        chk("b_mid_unst",  32'(b_unst), 32'h0);
        repeat (7) step();
        chk("b_re_early", 32'(b_out), 32'h1234);
        chk("b_re_valid0", 32'(b_valid), 32'h0);
        step();
        chk("b_re_out",   32'(b_out), 32'hFFFF);
        chk("b_re_chg",   32'(b_chg), 32'h1);
        chk("b_re_valid", 32'(b_valid), 32'h1);
        step();
        chk("b_re_chg2", 32'(b_chg), 32'h0);

        // Randomised 1-bit run against the reference model
        begin
            int cyc = 0;
            while (cyc < 5000) begin
                logic v;
                int   hold;
                v    = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 8));
                for (int h = 0; h < hold; h++) begin
                    c_in  = v;
                    c_clr = ($urandom_range(0, 15) == 0);
                    step();
                    chk("c_out",   32'(c_out),   32'(m_out));
                    chk("c_chg",   32'(c_chg),   32'(m_chg));
                    chk("c_valid", 32'(c_valid), 32'(m_valid));
                    chk("c_unst",  32'(c_unst),  32'(m_unst));
                    cyc++;
                end
            end
            c_clr = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
